mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates I/D cache block requests onto one shared memory port
// ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; undefined -> data cache always wins.
module mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               icache_read,
  input  logic [ADDR_W-1:0]  icache_address,
  output logic [BLOCK_W-1:0] icache_readdata,
  output logic               icache_busywait,
  input  logic               dcache_read,
  input  logic               dcache_write,
  input  logic [ADDR_W-1:0]  dcache_address,
  input  logic [BLOCK_W-1:0] dcache_writedata,
  output logic [BLOCK_W-1:0] dcache_readdata,
  output logic               dcache_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t state, state_next;
  logic   seen_busy;
  logic   i_req, d_req;
  logic   in_serve, complete;
  logic   grant_i, grant_d;
  logic   prefer_d;

  assign i_req    = icache_read;
  assign d_req    = dcache_read | dcache_write;
  assign in_serve = (state != IDLE);
  // A transaction only ends after memory has visibly been busy at least once.
  assign complete = in_serve && seen_busy && !mem_busywait;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_d <= 1'b0;
    end else if (grant_d) begin
      last_grant_d <= 1'b1;
    end else if (grant_i) begin
      last_grant_d <= 1'b0;
    end
  end

  assign prefer_d = !last_grant_d;
`else
  assign prefer_d = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || prefer_d)) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (complete) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port is driven only from the registers captured at grant time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen_busy     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else if (grant_d) begin
      seen_busy     <= 1'b0;
      mem_read      <= !dcache_write;
      mem_write     <= dcache_write;
      mem_address   <= dcache_address;
      mem_writedata <= dcache_writedata;
    end else if (grant_i) begin
      seen_busy     <= 1'b0;
      mem_read      <= 1'b1;
      mem_write     <= 1'b0;
      mem_address   <= icache_address;
      mem_writedata <= '0;
    end else if (complete) begin
      seen_busy     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
    end else if (in_serve && mem_busywait) begin
      seen_busy     <= 1'b1;
    end
  end

  assign icache_readdata = (state == SERVE_I) ? mem_readdata : '0;
  assign dcache_readdata = (state == SERVE_D) ? mem_readdata : '0;

  // Stall drops during the completion cycle so the cache captures data at that edge.
  assign icache_busywait = i_req && !((state == SERVE_I) && complete);
  assign dcache_busywait = d_req && !((state == SERVE_D) && complete);

endmodule
